sync_fifo_ctrl: RTL

//  Single-clock, parametrised FIFO: next generation of the team's FIFO for same-domain buffering.

---
 rtl/sync_fifo_ctrl_pkg.sv | 15 +
 rtl/sync_fifo_ctrl_ram_2p.sv | 26 ++
 rtl/sync_fifo_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared helpers for the single-clock FIFO: parameter legality check and
// pointer width derivation.
package sync_fifo_ctrl_pkg;

  function automatic bit fifo_params_ok(input int unsigned depth,
                                        input int unsigned afull,
                                        input int unsigned aempty);
    return (depth >= 2) && (afull >= 1) && (afull <= depth) && (aempty <= depth - 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_ram_2p.sv
// Storage array for sync_fifo_ctrl: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_ctrl_ram_2p #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: any depth, fill count, almost flags, sticky
// error status, and standard or first-word-fall-through read mode.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = 0,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  overflow_st,
  output logic                  underflow_st
);

  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);

  if (!fifo_params_ok(FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo_ctrl: illegal FIFO_DEPTH / AFULL_THRESH / AEMPTY_THRESH");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  overflow_st_q, overflow_st_d, underflow_st_q, underflow_st_d;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flags decode only the registered count, never the current requests.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
  assign count        = count_q;

  assign wr_ok = wr & ~full & ~flush;
  assign rd_ok = rd & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!wr_ok && rd_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    overflow_d     = wr & full & ~flush;
    underflow_d    = rd & empty & ~flush;
    // A new error in the same cycle as clr_err keeps the sticky bit set.
    overflow_st_d  = overflow_d | (overflow_st_q & ~clr_err);
    underflow_st_d = underflow_d | (underflow_st_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      overflow_st_q  <= 1'b0;
      underflow_st_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      overflow_st_q  <= overflow_st_d;
      underflow_st_q <= underflow_st_d;
    end
  end

  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign overflow_st  = overflow_st_q;
  assign underflow_st = underflow_st_q;

  sync_fifo_ctrl_ram_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .ADDR_W    (PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is presented straight from the array while data is stored.
    assign rdata = empty ? '0 : ram_rdata;
    assign valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) rdata_q <= ram_rdata;
      end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
  end

endmodule
